// File: rtl/datamem_arbiter_if.sv
// datamem_arbiter_if: requester and data-memory signals for datamem_arbiter
//   cpu_* / dbg_* : req, we, addr, wdata in; gnt, rvalid, rdata out (arbiter side)
//   mem_*         : raddr, waddr, read, write, wdata out; rdata in (arbiter side)
//   slave modport = arbiter, master modport = requesters + memory
interface datamem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_raddr, mem_waddr, mem_read, mem_write, mem_wdata,
    input  mem_rdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_raddr, mem_waddr, mem_read, mem_write, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: fixed-priority (cpu over dbg) data-memory arbiter with dbg starvation override
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset; grants are forced low while asserted
//   bus  : datamem_arbiter_if.slave (cpu/dbg request ports, memory drive)
//   DATAMEM_ARB_STATS_EN adds cpu_grant_cnt/dbg_grant_cnt (wrapping) and force_cnt (saturating)
module datamem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  datamem_arbiter_if.slave bus
`ifdef DATAMEM_ARB_STATS_EN
  ,
  output logic [15:0]      cpu_grant_cnt,
  output logic [15:0]      dbg_grant_cnt,
  output logic [7:0]       force_cnt
`endif
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0]    starve_cnt;
  logic          starved;
  logic          cpu_gnt;
  logic          dbg_gnt;
  logic          cpu_rd;
  logic          dbg_rd;
  logic          cpu_rv_q;
  logic          dbg_rv_q;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] addr;
  always_comb begin
    starved = starve_cnt == LIM;
    dbg_gnt = rst & bus.dbg_req & (~bus.cpu_req | starved);
    cpu_gnt = rst & bus.cpu_req & ~dbg_gnt;
    cpu_rd  = cpu_gnt & ~bus.cpu_we;
    dbg_rd  = dbg_gnt & ~bus.dbg_we;
    addr    = cpu_gnt ? bus.cpu_addr : dbg_gnt ? bus.dbg_addr : '0;
  end
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.mem_read   = cpu_rd | dbg_rd;
  assign bus.mem_write  = (cpu_gnt & bus.cpu_we) | (dbg_gnt & bus.dbg_we);
  assign bus.mem_raddr  = addr;
  assign bus.mem_waddr  = addr;
  assign bus.mem_wdata  = cpu_gnt ? bus.cpu_wdata : dbg_gnt ? bus.dbg_wdata : '0;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.dbg_rvalid = dbg_rv_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.dbg_rdata  = rdata_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      cpu_rv_q   <= 1'b0;
      dbg_rv_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      starve_cnt <= (dbg_gnt | ~bus.dbg_req) ? '0 : starved ? LIM : starve_cnt + 4'd1;
      cpu_rv_q   <= cpu_rd;
      dbg_rv_q   <= dbg_rd;
      if (cpu_rd | dbg_rd) rdata_q <= bus.mem_rdata;
    end
  end
`ifdef DATAMEM_ARB_STATS_EN
  // A grant is "forced" only when the cpu was also asking and lost to the override.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_grant_cnt <= '0;
      dbg_grant_cnt <= '0;
      force_cnt     <= '0;
    end else begin
      cpu_grant_cnt <= cpu_grant_cnt + {15'd0, cpu_gnt};
      dbg_grant_cnt <= dbg_grant_cnt + {15'd0, dbg_gnt};
      if (dbg_gnt & bus.cpu_req & starved & (force_cnt != 8'hFF)) force_cnt <= force_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_datamem_arbiter.sv
// tb_datamem_arbiter: directed + randomized checks of datamem_arbiter against a behavioural model
module tb_datamem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] shadow [1024];
  int checks = 0;
  int errors = 0;
  int denied = 0;
  bit exp_cpu_rv = 1'b0, exp_dbg_rv = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  bit last_c = 1'b0, last_d = 1'b0;
  datamem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
`ifdef DATAMEM_ARB_STATS_EN
  logic [15:0] cpu_grant_cnt, dbg_grant_cnt;
  logic [7:0]  force_cnt;
`endif
  datamem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DATAMEM_ARB_STATS_EN
    ,
    .cpu_grant_cnt(cpu_grant_cnt),
    .dbg_grant_cnt(dbg_grant_cnt),
    .force_cnt(force_cnt)
`endif
  );
  always #5 clk = ~clk;
  assign bus.cpu_req   = cpu_req;
  assign bus.cpu_we    = cpu_we;
  assign bus.cpu_addr  = cpu_addr;
  assign bus.cpu_wdata = cpu_wdata;
  assign bus.dbg_req   = dbg_req;
  assign bus.dbg_we    = dbg_we;
  assign bus.dbg_addr  = dbg_addr;
  assign bus.dbg_wdata = dbg_wdata;
  assign bus.mem_rdata = bus.mem_read ? ram[bus.mem_raddr] : 32'hBAD0BAD0;
  always @(posedge clk) if (bus.mem_write) ram[bus.mem_waddr] <= bus.mem_wdata;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Compare every output against the model for the current inputs, then advance the model.
  task automatic cycle();
    bit eg_d, eg_c, we;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    eg_d = rst && dbg_req && (!cpu_req || denied >= LIMIT);
    eg_c = rst && cpu_req && !eg_d;
    a  = eg_c ? cpu_addr : eg_d ? dbg_addr : '0;
    w  = eg_c ? cpu_wdata : eg_d ? dbg_wdata : '0;
    we = eg_c ? cpu_we : (eg_d && dbg_we);
    check("cpu_gnt", 32'(bus.cpu_gnt), 32'(eg_c));
    check("dbg_gnt", 32'(bus.dbg_gnt), 32'(eg_d));
    check("mem_read", 32'(bus.mem_read), 32'((eg_c || eg_d) && !we));
    check("mem_write", 32'(bus.mem_write), 32'((eg_c || eg_d) && we));
    check("mem_raddr", 32'(bus.mem_raddr), 32'(a));
    check("mem_waddr", 32'(bus.mem_waddr), 32'(a));
    check("mem_wdata", bus.mem_wdata, w);
    check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(exp_cpu_rv));
    check("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(exp_dbg_rv));
    check("cpu_rdata", bus.cpu_rdata, exp_rdata);
    check("dbg_rdata", bus.dbg_rdata, exp_rdata);
    last_c = eg_c;
    last_d = eg_d;
    if (!rst) begin
      denied = 0;
      exp_cpu_rv = 0;
      exp_dbg_rv = 0;
      exp_rdata = '0;
    end else begin
      denied = (eg_d || !dbg_req) ? 0 : (denied + 1 > LIMIT ? LIMIT : denied + 1);
      exp_cpu_rv = eg_c && !we;
      exp_dbg_rv = eg_d && !we;
      if ((eg_c || eg_d) && !we) exp_rdata = shadow[a];
      if ((eg_c || eg_d) && we) shadow[a] = w;
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'(i) * 32'h9E3779B9;
      shadow[i] = ram[i];
    end
    ram[1023] = 32'h12345678;
    shadow[1023] = 32'h12345678;
    // reset held with both requesters active
    cpu_req = 1; dbg_req = 1; cpu_addr = 10'h010; dbg_addr = 10'h100;
    @(negedge clk); #2;
    cycle();
    check("rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
    check("rst_dbg_gnt", 32'(bus.dbg_gnt), 0);
    check("rst_mem_strobe", 32'(bus.mem_read | bus.mem_write), 0);
    // release: cpu wins at once, starvation override every LIMIT+1 cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rst = 1; cpu_addr = 10'(k);
      #2;
      cycle();
      check($sformatf("starve_dbg_%0d", k), 32'(bus.dbg_gnt), 32'(k == 4 || k == 9));
      check($sformatf("starve_cpu_%0d", k), 32'(bus.cpu_gnt), 32'(!(k == 4 || k == 9)));
    end
    @(negedge clk);
    cpu_req = 0; dbg_req = 0;
    #2;
`ifdef DATAMEM_ARB_STATS_EN
    check("cpu_grant_cnt", 32'(cpu_grant_cnt), 8);
    check("dbg_grant_cnt", 32'(dbg_grant_cnt), 2);
    check("force_cnt", 32'(force_cnt), 2);
`endif
    cycle();
    // cpu write then read of the same word
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h005; cpu_wdata = 32'hDEADBEEF;
    #2;
    cycle();
    check("wr_mem_write", 32'(bus.mem_write), 1);
    check("wr_mem_waddr", 32'(bus.mem_waddr), 32'h005);
    @(negedge clk);
    cpu_we = 0;
    #2;
    cycle();
    check("rd_cpu_gnt", 32'(bus.cpu_gnt), 1);
    @(negedge clk);
    cpu_req = 0;
    #2;
    cycle();
    check("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 1);
    check("rd_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    // debug alone reads the top word
    @(negedge clk);
    dbg_req = 1; dbg_we = 0; dbg_addr = 10'h3FF;
    #2;
    cycle();
    check("dbg_alone_gnt", 32'(bus.dbg_gnt), 1);
    @(negedge clk);
    dbg_req = 0;
    #2;
    cycle();
    check("dbg_alone_rvalid", 32'(bus.dbg_rvalid), 1);
    check("dbg_alone_rdata", bus.dbg_rdata, 32'h12345678);
    check("dbg_alone_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    // reset lands between a read grant and its return
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
    #2;
    cycle();
    check("midrst_gnt", 32'(bus.cpu_gnt), 1);
    #1 rst = 0;
    exp_cpu_rv = 0; exp_dbg_rv = 0; exp_rdata = '0; denied = 0;
    @(negedge clk); #2;
    cycle();
    check("midrst_rvalid_in_rst", 32'(bus.cpu_rvalid), 0);
    check("midrst_strobe_in_rst", 32'(bus.mem_read | bus.mem_write), 0);
    @(negedge clk);
    rst = 1; cpu_req = 0;
    #2;
    cycle();
    check("midrst_rvalid_after", 32'(bus.cpu_rvalid), 0);
    // randomized traffic; pending requests mostly hold until granted, sometimes abandon
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!(cpu_req && !last_c && $urandom_range(0, 7) != 0)) begin
        cpu_req = $urandom_range(0, 3) != 0;
        cpu_we = 1'($urandom);
        cpu_addr = 10'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      if (!(dbg_req && !last_d && $urandom_range(0, 7) != 0)) begin
        dbg_req = $urandom_range(0, 2) == 0;
        dbg_we = 1'($urandom);
        dbg_addr = 10'($urandom_range(0, 15));
        dbg_wdata = $urandom;
      end
      #2;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
